lsu_stage: RTL and testbench

Parametrised load/store memory-access pipeline stage that drives the AHB-style data bus, sitting between execute and write-back. It sizes and aligns stores onto byte lanes, sign- or zero-extends sub-word loads, and honours bus wait states (HREADY) and error responses (HRESP) by stalling upstream. It detects misaligned accesses before any bus transfer. Non-memory instructions pass their ALU result straight through in one cycle.

---
 rtl/lsu_stage.sv | 213 +++++++++++++++++++++
 tb/tb_lsu_stage.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/lsu_stage.sv
// Load/store memory-access stage: drives an AHB-style data bus, aligns store lanes,
// extends sub-word loads, and passes non-memory results straight through.
module lsu_stage #(
  parameter int XLEN = 64,
  parameter int AW   = 64
) (
  input  logic            CLK,
  input  logic            RST,
  input  logic            EN,
  input  logic            LOAD,
  input  logic [1:0]      SIZE,
  input  logic            UNSIGNED,
  input  logic [AW-1:0]   address,
  input  logic [XLEN-1:0] value,
  input  logic [XLEN-1:0] alu_res,
  input  logic [4:0]      rd_i,
  input  logic            write_back,
  input  logic            stall,
  input  logic [XLEN-1:0] HRDATA,
  input  logic            HREADY,
  input  logic            HRESP,
  output logic [AW-1:0]   HADDR,
  output logic [XLEN-1:0] HWDATA,
  output logic            HWRITE,
  output logic [2:0]      HSIZE,
  output logic [1:0]      HTRANS,
  output logic [XLEN-1:0] res,
  output logic [4:0]      rd_o,
  output logic            mem_write_back_en,
  output logic            valid_o,
  output logic            busy,
  output logic            misalign,
  output logic            bus_fault
);
  localparam int OW = $clog2(XLEN / 8);

  typedef enum logic [1:0] {S_IDLE, S_ADDR, S_DATA} state_t;

  state_t          state_q, state_d;
  logic [AW-1:0]   haddr_q, haddr_d;
  logic [XLEN-1:0] hwdata_q, hwdata_d;
  logic            hwrite_q, hwrite_d;
  logic [2:0]      hsize_q, hsize_d;
  logic [1:0]      htrans_q, htrans_d;
  logic [XLEN-1:0] res_q, res_d;
  logic [4:0]      rd_q, rd_d;
  logic            wb_q, wb_d;
  logic            valid_q, valid_d;
  logic            mis_q, mis_d;
  logic            flt_q, flt_d;
  logic [4:0]      lrd_q, lrd_d;
  logic            lwb_q, lwb_d;
  logic            lload_q, lload_d;
  logic [1:0]      lsize_q, lsize_d;
  logic            luns_q, luns_d;
  logic [OW-1:0]   loff_q, loff_d;
  logic [XLEN-1:0] ldata_q, ldata_d;

  // Ones in the low 2^sz bytes; a full-width size yields an all-ones mask.
  function automatic logic [XLEN-1:0] lane_mask(input logic [1:0] sz);
    return ~({XLEN{1'b1}} << (8 << sz));
  endfunction

  function automatic logic [XLEN-1:0] extend_load(input logic [XLEN-1:0] d,
                                                  input logic [1:0] sz,
                                                  input logic uns);
    logic [XLEN-1:0] m;
    logic            sgn;
    m   = lane_mask(sz);
    sgn = |(d & m & ~(m >> 1));
    return (d & m) | ((sgn && !uns) ? ~m : '0);
  endfunction

  function automatic logic is_misaligned(input logic [AW-1:0] a, input logic [1:0] sz);
    case (sz)
      2'd0:    return 1'b0;
      2'd1:    return a[0];
      2'd2:    return |a[1:0];
      default: return (XLEN == 32) || (|a[2:0]);
    endcase
  endfunction

  always_comb begin
    state_d  = state_q;
    haddr_d  = haddr_q;
    hwdata_d = hwdata_q;
    hwrite_d = hwrite_q;
    hsize_d  = hsize_q;
    htrans_d = htrans_q;
    res_d    = res_q;
    rd_d     = rd_q;
    wb_d     = wb_q;
    valid_d  = 1'b0;
    mis_d    = 1'b0;
    flt_d    = 1'b0;
    lrd_d    = lrd_q;
    lwb_d    = lwb_q;
    lload_d  = lload_q;
    lsize_d  = lsize_q;
    luns_d   = luns_q;
    loff_d   = loff_q;
    ldata_d  = ldata_q;
    case (state_q)
      S_IDLE: begin
        if (!stall) begin
          if (!EN) begin
            res_d   = alu_res;
            rd_d    = rd_i;
            wb_d    = write_back;
            valid_d = 1'b1;
          end else if (is_misaligned(address, SIZE)) begin
            mis_d   = 1'b1;
            valid_d = 1'b1;
            wb_d    = 1'b0;
            rd_d    = rd_i;
          end else begin
            haddr_d  = address;
            hwrite_d = ~LOAD;
            hsize_d  = {1'b0, SIZE};
            htrans_d = 2'b10;
            lrd_d    = rd_i;
            lwb_d    = write_back;
            lload_d  = LOAD;
            lsize_d  = SIZE;
            luns_d   = UNSIGNED;
            loff_d   = address[OW-1:0];
            ldata_d  = value & lane_mask(SIZE);
            state_d  = S_ADDR;
          end
        end
      end
      S_ADDR: begin
        if (HREADY) begin
          htrans_d = 2'b00;
          if (!lload_q) hwdata_d = ldata_q << {loff_q, 3'b000};
          state_d  = S_DATA;
        end
      end
      S_DATA: begin
        if (HREADY) begin
          valid_d = 1'b1;
          rd_d    = lrd_q;
          state_d = S_IDLE;
          if (HRESP) begin
            flt_d = 1'b1;
            wb_d  = 1'b0;
          end else if (lload_q) begin
            res_d = extend_load(HRDATA >> {loff_q, 3'b000}, lsize_q, luns_q);
            wb_d  = lwb_q;
          end else begin
            res_d = '0;
            wb_d  = 1'b0;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q  <= S_IDLE;
      haddr_q  <= '0;
      hwdata_q <= '0;
      hwrite_q <= 1'b0;
      hsize_q  <= '0;
      htrans_q <= 2'b00;
      res_q    <= '0;
      rd_q     <= '0;
      wb_q     <= 1'b0;
      valid_q  <= 1'b0;
      mis_q    <= 1'b0;
      flt_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      haddr_q  <= haddr_d;
      hwdata_q <= hwdata_d;
      hwrite_q <= hwrite_d;
      hsize_q  <= hsize_d;
      htrans_q <= htrans_d;
      res_q    <= res_d;
      rd_q     <= rd_d;
      wb_q     <= wb_d;
      valid_q  <= valid_d;
      mis_q    <= mis_d;
      flt_q    <= flt_d;
    end
  end

  // Access context is only consumed while busy, so it needs no reset.
  always_ff @(posedge CLK) begin
    lrd_q   <= lrd_d;
    lwb_q   <= lwb_d;
    lload_q <= lload_d;
    lsize_q <= lsize_d;
    luns_q  <= luns_d;
    loff_q  <= loff_d;
    ldata_q <= ldata_d;
  end

  assign HADDR             = haddr_q;
  assign HWDATA            = hwdata_q;
  assign HWRITE            = hwrite_q;
  assign HSIZE             = hsize_q;
  assign HTRANS            = htrans_q;
  assign res               = res_q;
  assign rd_o              = rd_q;
  assign mem_write_back_en = wb_q;
  assign valid_o           = valid_q;
  assign busy              = (state_q != S_IDLE);
  assign misalign          = mis_q;
  assign bus_fault         = flt_q;
endmodule

// File: tb/tb_lsu_stage.sv
// Scoreboard bench for lsu_stage: expected write-back records are queued at stimulus
// time and retired by a monitor whenever valid_o pulses.
module tb_lsu_stage;
  localparam int XLEN = 64;
  localparam int AW   = 64;

  logic            CLK = 1'b0;
  logic            RST, EN, LOAD, UNSIGNED, write_back, stall, HREADY, HRESP;
  logic [1:0]      SIZE;
  logic [AW-1:0]   address;
  logic [XLEN-1:0] value, alu_res, HRDATA;
  logic [4:0]      rd_i;
  logic [AW-1:0]   HADDR;
  logic [XLEN-1:0] HWDATA, res;
  logic            HWRITE, mem_write_back_en, valid_o, busy, misalign, bus_fault;
  logic [2:0]      HSIZE;
  logic [1:0]      HTRANS;
  logic [4:0]      rd_o;

  lsu_stage #(.XLEN(XLEN), .AW(AW)) dut (
    .CLK(CLK), .RST(RST), .EN(EN), .LOAD(LOAD), .SIZE(SIZE), .UNSIGNED(UNSIGNED),
    .address(address), .value(value), .alu_res(alu_res), .rd_i(rd_i),
    .write_back(write_back), .stall(stall), .HRDATA(HRDATA), .HREADY(HREADY),
    .HRESP(HRESP), .HADDR(HADDR), .HWDATA(HWDATA), .HWRITE(HWRITE), .HSIZE(HSIZE),
    .HTRANS(HTRANS), .res(res), .rd_o(rd_o), .mem_write_back_en(mem_write_back_en),
    .valid_o(valid_o), .busy(busy), .misalign(misalign), .bus_fault(bus_fault)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [63:0] res;
    logic        chk_res;
    logic [4:0]  rd;
    logic        wb;
    logic        mis;
    logic        flt;
  } exp_t;

  exp_t sbq[$];
  int   checks = 0;
  int   failures = 0;

  task automatic cyc();
    @(posedge CLK);
    #1;
  endtask

  function automatic logic [63:0] model_load(input logic [63:0] d, input logic [2:0] off,
                                             input logic [1:0] sz, input logic uns);
    logic [63:0] s;
    s = d >> (8 * off);
    case (sz)
      2'd0:    return uns ? {56'b0, s[7:0]}  : {{56{s[7]}},  s[7:0]};
      2'd1:    return uns ? {48'b0, s[15:0]} : {{48{s[15]}}, s[15:0]};
      2'd2:    return uns ? {32'b0, s[31:0]} : {{32{s[31]}}, s[31:0]};
      default: return s;
    endcase
  endfunction

  function automatic logic [63:0] model_store(input logic [63:0] v, input logic [2:0] off,
                                              input logic [1:0] sz);
    logic [63:0] m;
    case (sz)
      2'd0:    m = {56'b0, v[7:0]};
      2'd1:    m = {48'b0, v[15:0]};
      2'd2:    m = {32'b0, v[31:0]};
      default: m = v;
    endcase
    return m << (8 * off);
  endfunction

  always @(negedge CLK) begin
    if (valid_o) begin
      checks++;
      if (sbq.size() == 0) begin
        failures++;
        $display("FAIL sb_unexpected_valid got res=%h rd=%0d wb=%b required no valid", res, rd_o, mem_write_back_en);
      end else begin
        exp_t e;
        e = sbq.pop_front();
        if ({rd_o, mem_write_back_en, misalign, bus_fault} !== {e.rd, e.wb, e.mis, e.flt}) begin
          failures++;
          $display("FAIL sb_ctrl got rd=%0d wb=%b mis=%b flt=%b required rd=%0d wb=%b mis=%b flt=%b",
                   rd_o, mem_write_back_en, misalign, bus_fault, e.rd, e.wb, e.mis, e.flt);
        end
        if (e.chk_res) begin
          checks++;
          if (res !== e.res) begin
            failures++;
            $display("FAIL sb_res got %h required %h", res, e.res);
          end
        end
      end
    end
  end

  task automatic do_access(input logic ld, input logic [1:0] sz, input logic uns,
                           input logic [63:0] addr, input logic [63:0] val,
                           input logic [63:0] rdata, input logic [4:0] rd,
                           input logic wbk, input logic flt, input int waits,
                           input logic stall_busy);
    exp_t e;
    int   lat, nbusy;
    logic [63:0] exp_wd;
    EN = 1; LOAD = ld; SIZE = sz; UNSIGNED = uns; address = addr; value = val;
    rd_i = rd; write_back = wbk; HREADY = 1; HRESP = 0; HRDATA = rdata; stall = 0;
    e.res = ld ? model_load(rdata, addr[2:0], sz, uns) : 64'h0;
    e.chk_res = !flt; e.rd = rd; e.wb = (ld && !flt) ? wbk : 1'b0; e.mis = 0; e.flt = flt;
    sbq.push_back(e);
    exp_wd = model_store(val, addr[2:0], sz);
    cyc();
    checks++;
    if ({HTRANS, HADDR, HSIZE, HWRITE, busy} !== {2'b10, addr, {1'b0, sz}, ~ld, 1'b1}) begin
      failures++;
      $display("FAIL addr_phase got htrans=%b haddr=%h hsize=%0d hwrite=%b busy=%b required 10 %h %0d %b 1",
               HTRANS, HADDR, HSIZE, HWRITE, busy, addr, sz, ~ld);
    end
    stall = stall_busy;
    lat = 0; nbusy = 1;
    for (int k = 1; k <= 20; k++) begin
      HREADY = (k == 1) || (k >= 2 + waits);
      HRESP  = flt && (k >= 2 + waits);
      cyc();
      if (k == 1) begin
        checks++;
        if (HTRANS !== 2'b00 || (!ld && HWDATA !== exp_wd)) begin
          failures++;
          $display("FAIL data_phase got htrans=%b hwdata=%h required 00 hwdata=%h", HTRANS, HWDATA, exp_wd);
        end
      end
      if (busy) begin
        nbusy++;
        checks++;
        if (HADDR !== addr) begin
          failures++;
          $display("FAIL haddr_stable got %h required %h", HADDR, addr);
        end
      end
      if (valid_o) begin
        lat = k;
        break;
      end
    end
    EN = 0; HREADY = 1; HRESP = 0; stall = 1;
    checks++;
    if (lat != 2 + waits || nbusy != 2 + waits) begin
      failures++;
      $display("FAIL latency got lat=%0d busy_cycles=%0d required %0d", lat, nbusy, 2 + waits);
    end
  endtask

  task automatic test_reset();
    RST = 1; EN = 0; LOAD = 0; SIZE = 0; UNSIGNED = 0; address = 0; value = 0; alu_res = 0;
    rd_i = 0; write_back = 0; stall = 1; HRDATA = 0; HREADY = 1; HRESP = 0;
    cyc(); cyc();
    checks++;
    if ({HTRANS, HWRITE, HSIZE, HADDR, HWDATA} !== '0) begin
      failures++;
      $display("FAIL reset_bus got htrans=%b hwrite=%b hsize=%0d haddr=%h hwdata=%h required all 0",
               HTRANS, HWRITE, HSIZE, HADDR, HWDATA);
    end
    checks++;
    if ({res, rd_o, mem_write_back_en, valid_o, misalign, bus_fault, busy} !== '0) begin
      failures++;
      $display("FAIL reset_out got res=%h rd=%0d wb=%b v=%b mis=%b flt=%b busy=%b required all 0",
               res, rd_o, mem_write_back_en, valid_o, misalign, bus_fault, busy);
    end
    RST = 0;
    cyc();
  endtask

  task automatic test_passthru();
    exp_t e;
    stall = 0; EN = 0; alu_res = 64'h1234; rd_i = 5; write_back = 1;
    e.res = 64'h1234; e.chk_res = 1; e.rd = 5; e.wb = 1; e.mis = 0; e.flt = 0;
    sbq.push_back(e);
    cyc();
    checks++;
    if (valid_o !== 1'b1 || HTRANS !== 2'b00) begin
      failures++;
      $display("FAIL passthru got valid=%b htrans=%b required 1 00", valid_o, HTRANS);
    end
    stall = 1; alu_res = 64'h9999; rd_i = 7;
    cyc();
    checks++;
    if (valid_o !== 1'b0 || res !== 64'h1234 || rd_o !== 5'd5) begin
      failures++;
      $display("FAIL stall_hold got valid=%b res=%h rd=%0d required 0 1234 5", valid_o, res, rd_o);
    end
  endtask

  task automatic test_misalign();
    exp_t e;
    stall = 0; EN = 1; LOAD = 1; SIZE = 2; address = 64'h3002; rd_i = 9; write_back = 1;
    e.res = 0; e.chk_res = 0; e.rd = 9; e.wb = 0; e.mis = 1; e.flt = 0;
    sbq.push_back(e);
    cyc();
    EN = 0; stall = 1;
    checks++;
    if (misalign !== 1'b1 || HTRANS !== 2'b00 || busy !== 1'b0 || mem_write_back_en !== 1'b0) begin
      failures++;
      $display("FAIL misalign got mis=%b htrans=%b busy=%b wb=%b required 1 00 0 0",
               misalign, HTRANS, busy, mem_write_back_en);
    end
    cyc();
    checks++;
    if (misalign !== 1'b0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL misalign_pulse got mis=%b busy=%b required 0 0", misalign, busy);
    end
  endtask

  task automatic test_loads_stores();
    do_access(1, 0, 0, 64'h1003, 0, 64'h00000000_80000000, 3, 1, 0, 0, 0);
    do_access(1, 0, 1, 64'h1003, 0, 64'h00000000_80000000, 4, 1, 0, 0, 0);
    do_access(0, 1, 0, 64'h2006, 64'hBEEF, 0, 6, 1, 0, 0, 0);
    do_access(1, 3, 1, 64'h4008, 0, 64'hF123_4567_89AB_CDEF, 8, 1, 0, 0, 0);
    for (int i = 0; i < 6; i++) begin
      logic [1:0] sz;
      logic [2:0] off;
      sz  = 2'($urandom_range(0, 3));
      off = 3'($urandom_range(0, 7)) & ~3'((1 << sz) - 1);
      do_access(1'($urandom_range(0, 1)), sz, 1'($urandom_range(0, 1)), 64'h8000 + 64'(off),
                {$urandom, $urandom}, {$urandom, $urandom}, 5'(10 + i), 1, 0, 0, 0);
    end
  endtask

  task automatic test_wait_states();
    do_access(1, 2, 0, 64'h5004, 0, 64'h8765_4321_0000_0000, 12, 1, 0, 3, 1);
    do_access(1, 2, 0, 64'h5004, 0, 64'h8765_4321_0000_0000, 13, 1, 1, 3, 0);
  endtask

  task automatic test_back_to_back();
    do_access(1, 1, 0, 64'h6002, 0, 64'h0000_0000_8001_0000, 20, 1, 0, 0, 0);
    do_access(0, 2, 0, 64'h6004, 64'hCAFE_F00D, 0, 21, 1, 0, 0, 0);
    do_access(1, 2, 1, 64'h6004, 0, 64'hCAFE_F00D_0000_0000, 22, 0, 0, 0, 0);
  endtask

  task automatic test_reset_in_addr();
    stall = 0; EN = 1; LOAD = 1; SIZE = 0; address = 64'h40; rd_i = 30; write_back = 1;
    HREADY = 0;
    cyc();
    RST = 1; EN = 0; stall = 1;
    cyc();
    checks++;
    if (HTRANS !== 2'b00 || busy !== 1'b0 || valid_o !== 1'b0) begin
      failures++;
      $display("FAIL rst_in_addr got htrans=%b busy=%b valid=%b required 00 0 0", HTRANS, busy, valid_o);
    end
    RST = 0; HREADY = 1;
    cyc(); cyc();
    checks++;
    if (valid_o !== 1'b0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL rst_abandon got valid=%b busy=%b required 0 0", valid_o, busy);
    end
  endtask

  initial begin
    test_reset();
    test_passthru();
    test_loads_stores();
    test_misalign();
    test_wait_states();
    test_back_to_back();
    test_reset_in_addr();
    cyc(); cyc();
    checks++;
    if (sbq.size() != 0) begin
      failures++;
      $display("FAIL sb_drain got %0d pending required 0", sbq.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
